// File: rtl/demux_1x8_deser_pkg.sv
// Shared sizing for the 1x8 deserializer and its 8:1 mux counterpart.
package demux_1x8_deser_pkg;
    localparam int WIDTH_DEF = 8;
    localparam int SEL_W_DEF = 3;
    localparam int LAST_LANE = WIDTH_DEF - 1;

    // Conceptual operating modes, implied by sel and y_valid rather than stored.
    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_COLLECT_PENDING,
        ST_STALL
    } deser_state_e;
endpackage

// File: rtl/demux_1x8_deser_if.sv
// Serial-in / word-out handshake bundle for the deserializer.
interface demux_1x8_deser_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
);
    logic             d_in;
    logic             d_valid;
    logic             d_ready;
    logic             clr;
    logic [0:SEL_W-1] sel;
    logic [0:WIDTH-1] y;
    logic             y_valid;
    logic             y_ready;

    modport master (
        output d_in, d_valid, clr, y_ready,
        input  d_ready, sel, y, y_valid
    );

    modport slave (
        input  d_in, d_valid, clr, y_ready,
        output d_ready, sel, y, y_valid
    );
endinterface

// File: rtl/demux_1x8_deser_lane_decoder.sv
// Lane pointer to one-hot write enable; the inverse of the mux select decode.
module lane_decoder_1x8 #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 3
) (
    input  logic [0:SEL_W-1] sel,
    input  logic             accept,
    output logic [0:WIDTH-1] en
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_en
        assign en[i] = accept & (sel == SEL_W'(i));
    end
endmodule

// File: rtl/demux_1x8_deser.sv
// 1x8 deserializer: steers each accepted bit to lane[sel] and emits the
// assembled word through a single-entry registered output slot.
module demux_1x8_deser
    import demux_1x8_deser_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input logic               clk,
    input logic               rst,
    demux_1x8_deser_if.slave  bus
);
    localparam int LAST = WIDTH - 1;

    logic [0:SEL_W-1] sel_q, sel_d;
    logic [0:WIDTH-1] lane_q, lane_d;
    logic [0:WIDTH-1] y_q, y_d;
    logic             y_valid_q, y_valid_d;
    logic [0:WIDTH-1] en;
    logic             at_last, d_ready, accept, consume;

    assign at_last = (sel_q == SEL_W'(LAST));
    // Only the completing bit can be blocked; earlier bits never need the slot.
    assign d_ready = !(at_last && y_valid_q && !bus.y_ready);
    assign accept  = bus.d_valid & d_ready;
    assign consume = y_valid_q & bus.y_ready;

    lane_decoder_1x8 #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_dec (
        .sel    (sel_q),
        .accept (accept),
        .en     (en)
    );

    always_comb begin
        sel_d     = sel_q;
        lane_d    = lane_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        if (consume) y_valid_d = 1'b0;
        if (bus.clr) begin
            sel_d  = '0;
            lane_d = '0;
        end else if (accept) begin
            for (int i = 0; i < WIDTH; i++)
                if (en[i]) lane_d[i] = bus.d_in;
            sel_d = sel_q + SEL_W'(1);
            if (at_last) begin
                // Completing bit bypasses the lane register straight into y.
                y_d       = lane_q;
                y_d[LAST] = bus.d_in;
                y_valid_d = 1'b1;
                lane_d    = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= '0;
            lane_q    <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            lane_q    <= lane_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
        end
    end

    assign bus.d_ready = d_ready;
    assign bus.sel     = sel_q;
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
endmodule

// File: tb/tb_demux_1x8_deser.sv
// Randomized + directed bench for demux_1x8_deser against a queue-based word model.
module tb_demux_1x8_deser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demux_1x8_deser_if #(.WIDTH(8), .SEL_W(3)) bus ();

    demux_1x8_deser dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int failures = 0;

    // Model: bits of the word in flight, plus the output slot.
    bit       mq[$];
    bit [7:0] m_y  = 8'h00;
    bit       m_yv = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_ready(input bit yr);
        return !(mq.size() == 7 && m_yv && !yr);
    endfunction

    task automatic step(input bit dv, input bit di, input bit cl, input bit yr, input bit rs);
        bit       rdy;
        bit [7:0] w;
        logic [7:0] yo;
        @(negedge clk);
        bus.d_valid = dv; bus.d_in = di; bus.clr = cl; bus.y_ready = yr; rst = rs;
        #1;
        rdy = model_ready(yr);
        chk("d_ready", bus.d_ready, rdy);
        if (rs) begin
            mq.delete(); m_y = 8'h00; m_yv = 1'b0;
        end else begin
            if (m_yv && yr) m_yv = 1'b0;
            if (cl) mq.delete();
            else if (dv && rdy) begin
                mq.push_back(di);
                if (mq.size() == 8) begin
                    w = 8'h00;
                    foreach (mq[i]) w = {w[6:0], mq[i]};
                    m_y = w; m_yv = 1'b1;
                    mq.delete();
                end
            end
        end
        @(posedge clk);
        #1;
        yo = bus.y;
        chk("sel", bus.sel, mq.size());
        chk("y", yo, m_y);
        chk("y_valid", bus.y_valid, m_yv);
    endtask

    // First bit sent is the MSB of w, which lands in y[0].
    task automatic send_bits(input bit [7:0] w, input int n, input bit yr);
        for (int i = 0; i < n; i++) step(1'b1, w[7-i], 1'b0, yr, 1'b0);
    endtask

    logic [7:0] yv;

    initial begin
        bus.d_in = 0; bus.d_valid = 0; bus.clr = 0; bus.y_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        yv = bus.y;
        chk("rst_y", yv, 8'h00);
        chk("rst_y_valid", bus.y_valid, 0);
        chk("rst_sel", bus.sel, 0);
        chk("rst_d_ready", bus.d_ready, 1);

        // Basic word
        send_bits(8'b10110010, 8, 1'b1);
        yv = bus.y;
        chk("basic_y", yv, 8'hB2);
        chk("basic_vld", bus.y_valid, 1);
        chk("basic_sel", bus.sel, 0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Backpressure
        send_bits(8'hA5, 8, 1'b0);
        send_bits(8'h5A, 7, 1'b0);
        chk("bp_ready", bus.d_ready, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        yv = bus.y;
        chk("bp_hold_y", yv, 8'hA5);
        chk("bp_hold_sel", bus.sel, 7);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        yv = bus.y;
        chk("bp_b_y", yv, 8'h5A);
        chk("bp_b_vld", bus.y_valid, 1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Gapped input
        for (int i = 0; i < 16; i++) begin
            step(1'b1, i[0] ^ i[2], 1'b0, 1'b1, 1'b0);
            step(1'b0, 1'($urandom), 1'b0, 1'b1, 1'b0);
            chk("gap_sel", bus.sel, (i + 1) % 8);
        end

        // clr mid-word
        send_bits(8'hFF, 5, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr_sel", bus.sel, 0);
        send_bits(8'h3C, 8, 1'b1);
        yv = bus.y;
        chk("clr_y", yv, 8'h3C);

        // rst mid-word with pending output
        send_bits(8'hFF, 8, 1'b0);
        send_bits(8'hAA, 4, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        yv = bus.y;
        chk("rst2_vld", bus.y_valid, 0);
        chk("rst2_y", yv, 8'h00);
        chk("rst2_sel", bus.sel, 0);
        send_bits(8'h01, 8, 1'b1);
        yv = bus.y;
        chk("rst2_next_y", yv, 8'h01);

        // Random traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 39) == 0,
                 1'($urandom), $urandom_range(0, 99) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/demux_1x8_deser.md
Name: demux_1x8_deser

Overview:
- Receiving end of the 8:1 select path: routes a serial bit stream, one bit per accepted beat, to lane y[sel], where sel is an internal 3-bit pointer.
- Each lane write is the inverse of the mux select decode.
- After 8 beats, presents the assembled 8-bit word on a registered output with a valid/ready handshake.
- Sits downstream of any block that emits bits through the mux, and rebuilds the parallel word.

Parameters:
- WIDTH, 8, number of lanes/output bits; must be a power of 2.
- SEL_W, 3, pointer width, equal to log2(WIDTH).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- d_in  input  1  serial data bit.
- d_valid  input  1  d_in is valid this cycle.
- d_ready  output  1  block can accept d_in this cycle.
- clr  input  1  synchronous flush of a partial word; does not touch the output register.
- sel  output  [0:SEL_W-1]  current lane pointer, i.e. the lane the next accepted bit writes.
- y  output  [0:WIDTH-1]  assembled word; y[0] is the first bit received.
- y_valid  output  1  y holds an unconsumed word.
- y_ready  input  1  consumer accepts y.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: sel=0, lane register=0, y=0, y_valid=0. d_ready is combinational and equals 1 after reset.
- Accept and consume:
  - accept = d_valid & d_ready.
  - consume = y_valid & y_ready.
- On accept:
  - lane[sel] <= d_in; all other lanes hold.
  - sel <= sel+1, wrapping from 7 to 0.
- Word completion (accept with sel==7):
  - y <= {lane[0..6], d_in}; the completing bit goes straight into y[7].
  - y_valid <= 1 on the next edge, so latency is 1 cycle from the 8th accepted bit to y_valid.
  - The lane register clears to 0.
- d_ready = !(sel==7 & y_valid & !y_ready).
  - Backpressure applies only when the word is about to complete and the output slot is still occupied.
  - Bits 0-6 of the next word are always accepted.
- y_valid:
  - Clears on consume, unless a word completes in the same cycle.
  - Consume and completion in the same cycle: y is overwritten with the new word and y_valid stays 1. Back-to-back words sustain 1 bit/cycle.
- y stays stable while y_valid=1 and y_ready=0.
- States: modelled by sel plus y_valid; no separate FSM is required.
  - COLLECT: sel in 0..7, y_valid=0.
  - COLLECT_PENDING: y_valid=1.
  - STALL: sel==7, y_valid=1, y_ready=0; d_ready=0.
- clr:
  - sel <= 0 and the lane register clears; any d_in accepted in the same cycle is dropped.
  - y and y_valid are unaffected; consume still works in that cycle.
- Priority: rst > clr > accept.
- Reset mid-word: the partial word is discarded with no output, and a pending y_valid drops.
- d_valid=0 holds all state; sel never advances without accept.

Decomposition:
- Shared package: WIDTH and SEL_W defaults and the lane index constant LAST_LANE = WIDTH-1, shared with the 8:1 mux side.
- One natural sub-module, lane_decoder_1x8:
  - Combinational sel to one-hot write enable.
  - Enables are gated by accept, e.g. sel=3'b010 gives en=8'b00100000 in [0:7] order.

Test Plan:
- Reset: after rst, y=0, y_valid=0, sel=0, d_ready=1.
- Basic word: y_ready=1, 8 consecutive beats 1,0,1,1,0,0,1,0 -> y=8'b10110010 with y_valid=1 exactly one cycle after the 8th beat; sel steps 0..7 then returns to 0.
- Backpressure:
  - Send word A=8'hA5 with y_ready=0, then 7 bits of word B -> d_ready=0 at sel==7 and y holds 8'hA5.
  - Raise y_ready -> A consumed, B's 8th bit accepted the same cycle, y=B next cycle, y_valid stays 1.
- Gapped input: d_valid toggled every other cycle over 16 beats -> two correct words, and sel frozen during gaps.
- clr after 5 bits, then 8 fresh bits 8'h3C -> y=8'h3C; no stale lanes appear in the output.
- rst after 4 bits while y_valid=1 with word 8'hFF -> next cycle y_valid=0, y=0, sel=0; the next 8 bits 8'h01 give y=8'h01.
